elastic_shiftbuffer: RTL

- Parametrised successor to the stall-driven shift buffer. Compacting shift-register buffer with full ready/valid handshake on both sides, so no input is silently dropped.
- Adds backpressure, occupancy count, almost-full flag and a synchronous flush.
- Sits between datapath pipeline stages, where downstream may stall for arbitrary cycles.

---
 rtl/elastic_shiftbuffer.sv | 92 +++++++++
 1 files changed

// File: rtl/elastic_shiftbuffer.sv
// Purpose : compacting shift-register buffer with ready/valid on both sides,
//           occupancy count, almost-full flag and synchronous flush.
// Latency : one cycle; a push into an empty buffer is visible on out after the edge.
// Backpressure: in_ready = (count < p_stages), registered state only; the head
//           holds steady while out_ready is low.
// Ports   : i_clk, i_rst (sync, active-high), i_flush (sync clear);
//           in/in_valid/in_ready upstream side; out/out_valid/out_ready downstream;
//           o_count occupancy, o_almost_full = (o_count >= p_afull).
module elastic_shiftbuffer #(
   parameter int p_stages = 6,
   parameter int p_width  = 32,
   parameter int p_afull  = p_stages - 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic [p_width-1:0]            in,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [p_width-1:0]            out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(p_stages+1)-1:0] o_count,
   output logic                          o_almost_full
);

   localparam int            cw      = $clog2(p_stages + 1);
   localparam logic [cw-1:0] c_full  = cw'(p_stages);
   localparam logic [cw-1:0] c_afull = cw'(p_afull);

   // Slot p_stages-1 is the head; valid entries fill downward from it.
   logic [p_width-1:0] slot_q [p_stages];
   logic [p_width-1:0] slot_d [p_stages];
   logic [cw-1:0]      count_q;
   logic [cw-1:0]      count_d;
   logic               afull_q;
   logic               push;
   logic               pop;
   int                 wr_idx;

   assign in_ready      = (count_q < c_full);
   assign out_valid     = (count_q != '0);
   assign out           = slot_q[p_stages-1];
   assign o_count       = count_q;
   assign o_almost_full = afull_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      // First free slot below the valid run.
      wr_idx  = p_stages - 1 - int'(count_q);
      if (pop) begin
         for (int i = p_stages - 1; i > 0; i--) begin
            slot_d[i] = slot_q[i-1];
         end
         slot_d[0] = '0;
         // After the shift the free slot has moved one place toward the head.
         wr_idx = p_stages - int'(count_q);
      end
      if (push) begin
         for (int i = 0; i < p_stages; i++) begin
            if (i == wr_idx) begin
               slot_d[i] = in;
            end
         end
      end
      if (push && !pop) begin
         count_d = count_q + cw'(1);
      end else if (pop && !push) begin
         count_d = count_q - cw'(1);
      end
   end

   // Reset and flush share the same clear; reset simply also covers flush.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         for (int i = 0; i < p_stages; i++) begin
            slot_q[i] <= '0;
         end
         count_q <= '0;
         afull_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         afull_q <= (count_d >= c_afull);
      end
   end

endmodule
